load_store_unit: RTL

//  Memory-stage load/store unit of the RV64I pipeline. Consumes the execute-stage ALU result as the effective address,

---
 rtl/load_store_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV64I memory-stage load/store unit. Drives a req/ready +
//               rvalid data-memory port and extends load data. It stalls
//               the pipeline until the access retires. Optional macro
//               LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of
//               masking the address.
// Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic        FlushM,
  input  logic [63:0] ALUResultM,
  input  logic [63:0] WriteDataM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [63:0] DMemAddr,
  output logic [63:0] DMemWData,
  output logic [7:0]  DMemBe,
  input  logic        DMemReady,
  input  logic [63:0] DMemRData,
  input  logic        DMemRValid,
  output logic [63:0] ReadDataM,
  output logic        LsuStall,
  output logic        MisalignedM,
  output logic        BusErr
);

  localparam int            CW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_tmo_last = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit            c_tmo_en   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_off;
  logic [2:0]      r_f3;
  logic [CW-1:0]   r_cnt;

  logic [1:0]      w_size;
  logic [2:0]      w_off;
  logic [2:0]      w_mask;
  logic [2:0]      w_off_eff;
  logic [7:0]      w_be;
  logic [63:0]     w_wdata;
  logic            w_op;
  logic            w_trap;
  logic            w_launch;
  logic            w_tmo;
  logic [63:0]     w_shifted;
  logic [63:0]     w_load;

  assign w_size = Funct3M[1:0];
  assign w_off  = ALUResultM[2:0];
  assign w_op   = (MemReadM | MemWriteM) & ~FlushM;

  // Offset bits that must be zero for a naturally aligned access of this size
  always_comb begin
    w_mask = 3'b111;
    case (w_size)
      2'd0:    w_mask = 3'b000;
      2'd1:    w_mask = 3'b001;
      2'd2:    w_mask = 3'b011;
      default: w_mask = 3'b111;
    endcase
  end

  assign w_off_eff = w_off & ~w_mask;

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis  = |(w_off & w_mask);
  assign w_trap = w_op & w_mis;
`else
  assign w_trap = 1'b0;
`endif

  assign w_launch    = w_op & ~w_trap;
  assign MisalignedM = w_trap;

  always_comb begin
    w_be    = 8'hFF;
    w_wdata = WriteDataM;
    case (w_size)
      2'd0: begin
        w_be    = 8'h01 << w_off_eff;
        w_wdata = {8{WriteDataM[7:0]}};
      end
      2'd1: begin
        w_be    = 8'h03 << w_off_eff;
        w_wdata = {4{WriteDataM[15:0]}};
      end
      2'd2: begin
        w_be    = 8'h0F << w_off_eff;
        w_wdata = {2{WriteDataM[31:0]}};
      end
      default: begin
        w_be    = 8'hFF;
        w_wdata = WriteDataM;
      end
    endcase
  end

  assign w_shifted = DMemRData >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_f3)
      3'b000:  w_load = {{56{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load = {{48{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = {{32{w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load = {56'd0, w_shifted[7:0]};
      3'b101:  w_load = {48'd0, w_shifted[15:0]};
      3'b110:  w_load = {32'd0, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  // Counter runs across REQ and WAIT combined, so its last value ends the access
  assign w_tmo = c_tmo_en && (r_cnt == c_tmo_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    LsuStall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        LsuStall = w_launch;
        if (w_launch) w_next_state = S_REQ;
      end
      S_REQ: begin
        LsuStall = 1'b1;
        if (DMemReady)  w_next_state = DMemWe ? S_DONE : S_WAIT;
        else if (w_tmo) w_next_state = S_DONE;
      end
      S_WAIT: begin
        LsuStall = 1'b1;
        if (DMemRValid || w_tmo) w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DMemReq   <= 1'b0;
      DMemWe    <= 1'b0;
      DMemAddr  <= 64'd0;
      DMemWData <= 64'd0;
      DMemBe    <= 8'd0;
      ReadDataM <= 64'd0;
      BusErr    <= 1'b0;
      r_off     <= 3'd0;
      r_f3      <= 3'd0;
      r_cnt     <= '0;
    end else begin
      BusErr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            DMemReq   <= 1'b1;
            DMemWe    <= MemWriteM;
            DMemAddr  <= {ALUResultM[63:3], 3'b000};
            DMemWData <= w_wdata;
            DMemBe    <= w_be;
            r_off     <= w_off_eff;
            r_f3      <= Funct3M;
            r_cnt     <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (DMemReady) begin
            DMemReq <= 1'b0;
          end else if (w_tmo) begin
            DMemReq <= 1'b0;
            BusErr  <= 1'b1;
            if (!DMemWe) ReadDataM <= 64'd0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (DMemRValid) begin
            ReadDataM <= w_load;
          end else if (w_tmo) begin
            BusErr    <= 1'b1;
            ReadDataM <= 64'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
